// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MM stage: mm_ctl bit positions, FSM states and WB encodings.
package mem_stage_pkg;

    localparam int unsigned MM_LOAD  = 0;
    localparam int unsigned MM_STORE = 1;
    localparam int unsigned MM_FDEST = 2;

    localparam logic [3:0] WB_NONE = 4'b0000;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } mm_state_t;

    function automatic logic is_mem_op(input logic [2:0] ctl);
        return ctl[MM_LOAD] | ctl[MM_STORE];
    endfunction

    // Store wins when both bits are set, so only a pure load returns memory data.
    function automatic logic is_load_only(input logic [2:0] ctl);
        return ctl[MM_LOAD] & ~ctl[MM_STORE];
    endfunction

endpackage

// File: rtl/mem_stage_pipe_reg.sv
// EX/MM pipeline register: loads when enabled, substituting a bubble for busy or faulting EX slots.
module mm_pipe_reg
    import mem_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load_en,
    input  logic        ex_busy,
    input  logic        ex_exc,
    input  logic [2:0]  mm_ctl,
    input  logic        result_P,
    input  logic [31:0] result_I,
    input  logic [31:0] result_F,
    input  logic [3:0]  WB_in,
    output logic [2:0]  q_ctl,
    output logic        q_p,
    output logic [31:0] q_i,
    output logic [31:0] q_f,
    output logic [3:0]  q_wb,
    output logic        q_exc
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_ctl <= '0;
            q_p   <= 1'b0;
            q_i   <= '0;
            q_f   <= '0;
            q_wb  <= WB_NONE;
            q_exc <= 1'b0;
        end else if (load_en) begin
            if (ex_busy || ex_exc) begin
                q_ctl <= '0;
                q_p   <= 1'b0;
                q_i   <= '0;
                q_f   <= '0;
                q_wb  <= WB_NONE;
                // A faulting slot is still a bubble, but remembers the fault for one cycle.
                q_exc <= ex_exc & ~ex_busy;
            end else begin
                q_ctl <= mm_ctl;
                q_p   <= result_P;
                q_i   <= result_I;
                q_f   <= result_F;
                q_wb  <= WB_in;
                q_exc <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/mem_stage.sv
// MM pipeline stage: EX/MM register, req/ack data-memory access FSM, forwarding and WB bundle.
// Optional macro MM_TIMEOUT_EN adds an ack-wait timeout that aborts the access with a bus error.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned AW      = 32,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ex_busy,
    input  logic          ex_exc,
    input  logic [2:0]    mm_ctl,
    input  logic          result_P,
    input  logic [31:0]   result_I,
    input  logic [31:0]   result_F,
    input  logic [31:0]   Wdata,
    input  logic [3:0]    WB_in,
    output logic          dmem_req,
    output logic          dmem_we,
    output logic [AW-1:0] dmem_addr,
    output logic [31:0]   dmem_wdata,
    input  logic          dmem_ack,
    input  logic [31:0]   dmem_rdata,
    output logic          mm_stall,
    output logic          pval_mm,
    output logic [31:0]   rval_mm,
    output logic [31:0]   fval_mm,
    output logic [3:0]    WB_out,
    output logic          wb_pval,
    output logic [31:0]   wb_rval,
    output logic [31:0]   wb_fval,
    output logic [1:0]    mm_exc
);

    if (AW < 3 || AW > 32 || TIMEOUT < 1 || TIMEOUT > 16) begin : g_param_check
        $error("mem_stage: AW must be 3..32 and TIMEOUT 1..16");
    end

    mm_state_t   state;
    logic        pipe_en;
    logic        capture_mem;
    logic [2:0]  q_ctl;
    logic        q_p;
    logic [31:0] q_i;
    logic [31:0] q_f;
    logic [3:0]  q_wb;
    logic        q_exc;
    logic        q_load;
    logic [31:0] ld_data;

`ifdef MM_TIMEOUT_EN
    localparam logic [3:0] WAIT_LAST = 4'(TIMEOUT - 1);
    logic [3:0] wait_cnt;
    logic       aborted;
    logic       bus_err;
`endif

    assign pipe_en     = (state == ST_IDLE);
    assign capture_mem = ~ex_busy & ~ex_exc & is_mem_op(mm_ctl);

    mm_pipe_reg u_pipe (
        .clk      (clk),
        .rst      (rst),
        .load_en  (pipe_en),
        .ex_busy  (ex_busy),
        .ex_exc   (ex_exc),
        .mm_ctl   (mm_ctl),
        .result_P (result_P),
        .result_I (result_I),
        .result_F (result_F),
        .WB_in    (WB_in),
        .q_ctl    (q_ctl),
        .q_p      (q_p),
        .q_i      (q_i),
        .q_f      (q_f),
        .q_wb     (q_wb),
        .q_exc    (q_exc)
    );

    // The request is launched from the raw EX inputs on the capture edge so that
    // dmem_req rises in the very next cycle while the EX/MM register freezes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            ld_data    <= '0;
`ifdef MM_TIMEOUT_EN
            wait_cnt   <= '0;
            aborted    <= 1'b0;
            bus_err    <= 1'b0;
`endif
        end else begin
`ifdef MM_TIMEOUT_EN
            bus_err <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
`ifdef MM_TIMEOUT_EN
                    aborted <= 1'b0;
`endif
                    if (capture_mem) begin
                        state      <= ST_ACCESS;
                        dmem_req   <= 1'b1;
                        dmem_we    <= mm_ctl[MM_STORE];
                        dmem_addr  <= {result_I[AW-1:2], 2'b00};
                        dmem_wdata <= Wdata;
`ifdef MM_TIMEOUT_EN
                        wait_cnt   <= '0;
`endif
                    end
                end
                ST_ACCESS: begin
                    if (dmem_ack) begin
                        state    <= ST_IDLE;
                        dmem_req <= 1'b0;
                        dmem_we  <= 1'b0;
                        ld_data  <= dmem_rdata;
                    end
`ifdef MM_TIMEOUT_EN
                    else if (wait_cnt == WAIT_LAST) begin
                        state    <= ST_IDLE;
                        dmem_req <= 1'b0;
                        dmem_we  <= 1'b0;
                        aborted  <= 1'b1;
                        bus_err  <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
`endif
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign q_load   = is_load_only(q_ctl);
    assign mm_stall = (state == ST_ACCESS) & ~dmem_ack;

    // The EX/MM register still holds the finished memory op in the cycle after ack,
    // so the WB bundle is steered from it plus the latched load data.
    always_comb begin
        WB_out  = (state == ST_IDLE) ? q_wb : WB_NONE;
`ifdef MM_TIMEOUT_EN
        if (aborted) begin
            WB_out = WB_NONE;
        end
`endif
        wb_pval = q_p;
        wb_rval = (q_load & ~q_ctl[MM_FDEST]) ? ld_data : q_i;
        wb_fval = (q_load &  q_ctl[MM_FDEST]) ? ld_data : q_f;
    end

    assign pval_mm = q_p;
    assign rval_mm = q_i;
    assign fval_mm = q_f;

`ifdef MM_TIMEOUT_EN
    assign mm_exc = {bus_err, q_exc};
`else
    assign mm_exc = {1'b0, q_exc};
`endif

endmodule
